// File: rtl/uart_wb_pkg.sv
// ============================================================================
// uart_wb_pkg : shared types, lane constants and read-lane helper
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] SEL_B0   = 4'b0001;
   localparam logic [3:0] SEL_B1   = 4'b0010;
   localparam logic [3:0] SEL_B2   = 4'b0100;
   localparam logic [3:0] SEL_B3   = 4'b1000;
   localparam logic [3:0] SEL_WORD = 4'b1111;

   // Zero-extended byte for a single-lane select, whole word for SEL_WORD.
   function automatic logic [31:0] lane_extract(input logic [3:0]  sel,
                                                input logic [31:0] dat);
      case (sel)
         SEL_B0:   return {24'h0, dat[7:0]};
         SEL_B1:   return {24'h0, dat[15:8]};
         SEL_B2:   return {24'h0, dat[23:16]};
         SEL_B3:   return {24'h0, dat[31:24]};
         SEL_WORD: return dat;
         default:  return 32'h0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_wb_lane_steer.sv
// ============================================================================
// uart_wb_lane_steer : byte-lane select / write replication / read extraction
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_wb_lane_steer
   import uart_wb_pkg::*;
(
   input  logic        word_i,
   input  logic [1:0]  adr_lo_i,
   input  logic [31:0] wdat_i,
   output logic [3:0]  sel_o,
   output logic [31:0] wdat_o,
   input  logic [3:0]  rsel_i,
   input  logic [31:0] rdat_i,
   output logic [31:0] rdat_o
);

   always_comb begin
      sel_o  = SEL_WORD;
      wdat_o = wdat_i;
      if (!word_i) begin
         sel_o  = SEL_B0 << adr_lo_i;
         wdat_o = {4{wdat_i[7:0]}};
      end
   end

   always_comb begin
      rdat_o = lane_extract(rsel_i, rdat_i);
   end

endmodule

`default_nettype wire

// File: rtl/uart_wb_master.sv
// ============================================================================
// uart_wb_master : single-command Wishbone classic initiator with timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_wb_master
   import uart_wb_pkg::*;
#(
   parameter int ADR_WIDTH = 5,
   parameter int TIMEOUT   = 255,
   parameter int TO_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 wb_rst_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic                 cmd_we_i,
   input  logic                 cmd_word_i,
   input  logic [ADR_WIDTH-1:0] cmd_adr_i,
   input  logic [31:0]          cmd_dat_i,
   output logic                 rsp_valid_o,
   output logic [31:0]          rsp_dat_o,
   output logic                 rsp_err_o,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic                 wb_we_o,
   output logic [ADR_WIDTH-1:0] wb_adr_o,
   output logic [3:0]           wb_sel_o,
   output logic [31:0]          wb_dat_o,
   input  logic [31:0]          wb_dat_i,
   input  logic                 wb_ack_i
);

   state_t                 state_q, state_d;
   logic [TO_WIDTH-1:0]    cnt_q, cnt_d;
   logic                   cyc_q, cyc_d;
   logic                   we_q, we_d;
   logic [ADR_WIDTH-1:0]   adr_q, adr_d;
   logic [3:0]             sel_q, sel_d;
   logic [31:0]            dat_q, dat_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic                   rsp_err_q, rsp_err_d;
   logic [31:0]            rsp_dat_q, rsp_dat_d;

   logic                   accept;
   logic                   ack_hit;
   logic                   expire;
   logic [3:0]             steer_sel;
   logic [31:0]            steer_wdat;
   logic [31:0]            steer_rdat;

   uart_wb_lane_steer u_steer (
      .word_i   (cmd_word_i),
      .adr_lo_i (cmd_adr_i[1:0]),
      .wdat_i   (cmd_dat_i),
      .sel_o    (steer_sel),
      .wdat_o   (steer_wdat),
      .rsel_i   (sel_q),
      .rdat_i   (wb_dat_i),
      .rdat_o   (steer_rdat)
   );

   assign accept  = (state_q == IDLE) && cmd_valid_i;
   assign ack_hit = (state_q == BUS) && wb_ack_i;
   // Ack takes priority over expiry when both land on the same edge.
   assign expire  = (state_q == BUS) && !wb_ack_i &&
                    (cnt_q == TO_WIDTH'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = BUS;
         BUS:     if (ack_hit || expire) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      adr_d       = adr_q;
      sel_d       = sel_q;
      dat_d       = dat_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_dat_d   = rsp_dat_q;
      if (accept) begin
         cyc_d = 1'b1;
         cnt_d = '0;
         we_d  = cmd_we_i;
         sel_d = steer_sel;
         dat_d = steer_wdat;
         adr_d = cmd_adr_i;
         if (cmd_word_i) adr_d[1:0] = 2'b00;
      end
      if (state_q == BUS) begin
         if (ack_hit) begin
            cyc_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            if (!we_q) rsp_dat_d = steer_rdat;
         end else if (expire) begin
            cyc_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_dat_d   = 32'h0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cnt_q       <= '0;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         sel_q       <= 4'h0;
         dat_q       <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_dat_q   <= 32'h0;
      end else begin
         cnt_q       <= cnt_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         sel_q       <= sel_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_dat_q   <= rsp_dat_d;
      end
   end

   assign cmd_ready_o = (state_q == IDLE);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_dat_o   = rsp_dat_q;
   assign wb_cyc_o    = cyc_q;
   assign wb_stb_o    = cyc_q;
   assign wb_we_o     = we_q;
   assign wb_adr_o    = adr_q;
   assign wb_sel_o    = sel_q;
   assign wb_dat_o    = dat_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_wb_master.sv
// ============================================================================
// tb_uart_wb_master : directed self-checking bench for uart_wb_master
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_wb_master;

   logic        clk = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_we_i = 1'b0;
   logic        cmd_word_i = 1'b0;
   logic [4:0]  cmd_adr_i = 5'h0;
   logic [31:0] cmd_dat_i = 32'h0;
   logic        rsp_valid_o;
   logic [31:0] rsp_dat_o;
   logic        rsp_err_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [4:0]  wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i = 32'h0;
   logic        wb_ack_i = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_wb_master #(.ADR_WIDTH(5), .TIMEOUT(4), .TO_WIDTH(8)) dut (
      .clk         (clk),
      .wb_rst_i    (wb_rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_we_i    (cmd_we_i),
      .cmd_word_i  (cmd_word_i),
      .cmd_adr_i   (cmd_adr_i),
      .cmd_dat_i   (cmd_dat_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_dat_o   (rsp_dat_o),
      .rsp_err_o   (rsp_err_o),
      .wb_cyc_o    (wb_cyc_o),
      .wb_stb_o    (wb_stb_o),
      .wb_we_o     (wb_we_o),
      .wb_adr_o    (wb_adr_o),
      .wb_sel_o    (wb_sel_o),
      .wb_dat_o    (wb_dat_o),
      .wb_dat_i    (wb_dat_i),
      .wb_ack_i    (wb_ack_i)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command; ack_at = BUS cycle (1-based) in which ack is driven, 0 = never.
   task automatic do_cmd(input logic we, input logic word, input logic [4:0] adr,
                         input logic [31:0] dat, input int ack_at, input logic [31:0] rdat,
                         output int stb_cycles, output logic got_rsp, output logic err,
                         output logic [31:0] rspd, output logic [3:0] sel,
                         output logic [31:0] wdat, output logic [4:0] wadr, output logic wwe);
      cmd_valid_i = 1'b1;
      cmd_we_i    = we;
      cmd_word_i  = word;
      cmd_adr_i   = adr;
      cmd_dat_i   = dat;
      tick();
      cmd_valid_i = 1'b0;
      sel  = wb_sel_o;
      wdat = wb_dat_o;
      wadr = wb_adr_o;
      wwe  = wb_we_o;
      stb_cycles = 0;
      got_rsp = 1'b0;
      err  = 1'b0;
      rspd = 32'h0;
      for (int k = 1; k <= 20; k++) begin
         if (wb_stb_o) stb_cycles++;
         wb_ack_i = (k == ack_at);
         wb_dat_i = rdat;
         tick();
         wb_ack_i = 1'b0;
         if (rsp_valid_o) begin
            got_rsp = 1'b1;
            err  = rsp_err_o;
            rspd = rsp_dat_o;
            break;
         end
      end
      check_val("rsp_seen", {31'h0, got_rsp}, 32'h1);
      check_val("stb_low_in_resp", {31'h0, wb_stb_o}, 32'h0);
      tick();
      check_val("rsp_one_cycle", {31'h0, rsp_valid_o}, 32'h0);
      check_val("ready_after", {31'h0, cmd_ready_o}, 32'h1);
   endtask

   int          sc;
   logic        gr, er, we_s;
   logic [31:0] rd, wd;
   logic [3:0]  sl;
   logic [4:0]  ad;

   initial begin
      tick();
      tick();
      check_val("rst_ready", {31'h0, cmd_ready_o}, 32'h1);
      check_val("rst_valid", {31'h0, rsp_valid_o}, 32'h0);
      check_val("rst_err", {31'h0, rsp_err_o}, 32'h0);
      check_val("rst_rdat", rsp_dat_o, 32'h0);
      check_val("rst_cyc_stb_we", {29'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'h0);
      check_val("rst_adr", {27'h0, wb_adr_o}, 32'h0);
      check_val("rst_sel", {28'h0, wb_sel_o}, 32'h0);
      check_val("rst_wdat", wb_dat_o, 32'h0);
      wb_rst_i = 1'b0;
      tick();

      // Byte write, lane 3
      do_cmd(1'b1, 1'b0, 5'h03, 32'h0000_00A5, 2, 32'hFFFF_FFFF, sc, gr, er, rd, sl, wd, ad, we_s);
      check_val("bw_sel", {28'h0, sl}, 32'h8);
      check_val("bw_dat", wd, 32'hA5A5_A5A5);
      check_val("bw_we", {31'h0, we_s}, 32'h1);
      check_val("bw_adr", {27'h0, ad}, 32'h03);
      check_val("bw_stb_cycles", sc, 2);
      check_val("bw_err", {31'h0, er}, 32'h0);
      check_val("bw_rdat_unchanged", rd, 32'h0);
      check_val("bw_hold_sel", {28'h0, wb_sel_o}, 32'h8);
      check_val("bw_hold_dat", wb_dat_o, 32'hA5A5_A5A5);

      // Ack while idle must be ignored
      wb_ack_i = 1'b1;
      tick();
      wb_ack_i = 1'b0;
      check_val("idle_ack_cyc", {31'h0, wb_cyc_o}, 32'h0);
      check_val("idle_ack_valid", {31'h0, rsp_valid_o}, 32'h0);
      check_val("idle_ack_ready", {31'h0, cmd_ready_o}, 32'h1);

      // Byte read, lane 2
      do_cmd(1'b0, 1'b0, 5'h02, 32'h0, 2, 32'h1122_3344, sc, gr, er, rd, sl, wd, ad, we_s);
      check_val("br_sel", {28'h0, sl}, 32'h4);
      check_val("br_we", {31'h0, we_s}, 32'h0);
      check_val("br_rdat", rd, 32'h0000_0022);
      check_val("br_err", {31'h0, er}, 32'h0);

      // Word read, unaligned address
      do_cmd(1'b0, 1'b1, 5'h07, 32'h0, 2, 32'hDEAD_BEEF, sc, gr, er, rd, sl, wd, ad, we_s);
      check_val("wr_adr", {27'h0, ad}, 32'h04);
      check_val("wr_sel", {28'h0, sl}, 32'hF);
      check_val("wr_rdat", rd, 32'hDEAD_BEEF);

      // Word write keeps previous read data
      do_cmd(1'b1, 1'b1, 5'h0A, 32'hCAFE_F00D, 2, 32'h0, sc, gr, er, rd, sl, wd, ad, we_s);
      check_val("ww_adr", {27'h0, ad}, 32'h08);
      check_val("ww_dat", wd, 32'hCAFE_F00D);
      check_val("ww_rdat_kept", rd, 32'hDEAD_BEEF);

      // Timeout, no ack
      do_cmd(1'b0, 1'b1, 5'h10, 32'h0, 0, 32'h0, sc, gr, er, rd, sl, wd, ad, we_s);
      check_val("to_stb_cycles", sc, 4);
      check_val("to_err", {31'h0, er}, 32'h1);
      check_val("to_rdat", rd, 32'h0);

      // Ack on the exact expiry cycle wins
      do_cmd(1'b0, 1'b1, 5'h14, 32'h0, 4, 32'h1234_5678, sc, gr, er, rd, sl, wd, ad, we_s);
      check_val("edge_stb_cycles", sc, 4);
      check_val("edge_err", {31'h0, er}, 32'h0);
      check_val("edge_rdat", rd, 32'h1234_5678);

      // Reset while strobe is high
      cmd_valid_i = 1'b1;
      cmd_we_i    = 1'b1;
      cmd_word_i  = 1'b1;
      cmd_adr_i   = 5'h08;
      cmd_dat_i   = 32'h5555_AAAA;
      tick();
      cmd_valid_i = 1'b0;
      check_val("rm_stb_before", {31'h0, wb_stb_o}, 32'h1);
      #2;
      wb_rst_i = 1'b1;
      #1;
      check_val("rm_cyc_async", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
      tick();
      wb_rst_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check_val("rm_no_rsp", {31'h0, rsp_valid_o}, 32'h0);
         tick();
      end
      check_val("rm_ready", {31'h0, cmd_ready_o}, 32'h1);
      do_cmd(1'b0, 1'b0, 5'h01, 32'h0, 2, 32'hAABB_CCDD, sc, gr, er, rd, sl, wd, ad, we_s);
      check_val("rm_next_sel", {28'h0, sl}, 32'h2);
      check_val("rm_next_rdat", rd, 32'h0000_00CC);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
